logic_unit_seq: RTL

- Parametrised, multi-cycle bitwise logic unit for the Y86 pipe execute path.
- Generalises the fixed 64-bit XOR to WIDTH bits and four ops (XOR/AND/OR/XNOR).
- Processes operands CHUNK bits per cycle, LSB slice first.
- Valid/ready handshake on both sides; produces the result plus Y86-style ZF/SF condition flags.

---
 rtl/logic_unit_seq_if.sv | 49 ++++
 rtl/logic_unit_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/logic_unit_seq_if.sv
// logic_unit_seq_if
//   Handshake/bus bundle for logic_unit_seq.
//   master : operand source and result consumer (drives in_valid/op/a/b/out_ready)
//   slave  : the logic unit (drives in_ready/out_valid/result/zf/sf[/pf])
//   Signals:
//     in_valid, in_ready : operand-side handshake
//     op[1:0]            : 00 XOR, 01 AND, 10 OR, 11 XNOR
//     a, b [WIDTH-1:0]   : operands
//     out_valid,out_ready: result-side handshake
//     result[WIDTH-1:0]  : op(a,b)
//     zf, sf             : result==0, result MSB
//     pf                 : even parity of result (only with LOGIC_UNIT_PARITY_EN)
interface logic_unit_seq_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zf;
  logic             sf;
`ifdef LOGIC_UNIT_PARITY_EN
  logic             pf;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zf, sf, pf
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zf, sf, pf
  );
`else
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zf, sf
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zf, sf
  );
`endif
endinterface

// File: rtl/logic_unit_seq.sv
// logic_unit_seq
//   Multi-cycle bitwise logic unit (XOR/AND/OR/XNOR) for the Y86 execute path.
//   Operands are latched on acceptance and processed CHUNK bits per cycle,
//   LSB slice first, over NCH = WIDTH/CHUNK cycles. Produces result plus
//   Y86-style ZF/SF flags behind a valid/ready handshake.
//   Optional macro LOGIC_UNIT_PARITY_EN adds pf (even parity of result).
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : logic_unit_seq_if.slave (in_valid/in_ready/op/a/b,
//             out_valid/out_ready/result/zf/sf[/pf])
//   FSM: IDLE (in_ready=1) -> BUSY (NCH cycles) -> DONE (out_valid=1) -> IDLE
module logic_unit_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  logic_unit_seq_if.slave   bus
);

  localparam int NCH = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Reject configurations that cannot be split into whole slices.
  generate
    if (CHUNK <= 0) begin : g_bad_chunk
      $error("logic_unit_seq: CHUNK must be greater than zero");
    end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
      $error("logic_unit_seq: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  logic [1:0]       state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] result_reg;
  logic             zero_reg;   // running "all slices so far were zero"
  logic             zf_reg;
  logic             sf_reg;
`ifdef LOGIC_UNIT_PARITY_EN
  logic             par_reg;    // running XOR of all result bits so far
  logic             pf_reg;
`endif

  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK-1:0] slice_next;
  logic             slice_zero;

  // One CHUNK-wide datapath, steered onto the current slice by the counter.
  assign a_slice = a_reg[int'(cnt_reg) * CHUNK +: CHUNK];
  assign b_slice = b_reg[int'(cnt_reg) * CHUNK +: CHUNK];

  always_comb begin
    slice_next = '0;
    case (op_reg)
      2'b00:   slice_next = a_slice ^ b_slice;
      2'b01:   slice_next = a_slice & b_slice;
      2'b10:   slice_next = a_slice | b_slice;
      default: slice_next = ~(a_slice ^ b_slice);
    endcase
  end

  assign slice_zero = (slice_next == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      zero_reg   <= 1'b0;
      zf_reg     <= 1'b0;
      sf_reg     <= 1'b0;
`ifdef LOGIC_UNIT_PARITY_EN
      par_reg    <= 1'b0;
      pf_reg     <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_reg      <= bus.a;
            b_reg      <= bus.b;
            op_reg     <= bus.op;
            result_reg <= '0;
            zero_reg   <= 1'b1;
            cnt_reg    <= '0;
`ifdef LOGIC_UNIT_PARITY_EN
            par_reg    <= 1'b0;
`endif
            state_reg  <= S_BUSY;
          end
        end
        S_BUSY: begin
          result_reg[int'(cnt_reg) * CHUNK +: CHUNK] <= slice_next;
          zero_reg <= zero_reg & slice_zero;
`ifdef LOGIC_UNIT_PARITY_EN
          par_reg  <= par_reg ^ (^slice_next);
`endif
          if (cnt_reg == LAST) begin
            // Flags fold in the final slice directly rather than waiting a
            // cycle for the running registers to catch up.
            zf_reg    <= zero_reg & slice_zero;
            sf_reg    <= slice_next[CHUNK-1];
`ifdef LOGIC_UNIT_PARITY_EN
            pf_reg    <= ~(par_reg ^ (^slice_next));
`endif
            cnt_reg   <= '0;
            state_reg <= S_DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == S_IDLE);
  assign bus.out_valid = (state_reg == S_DONE);
  assign bus.result    = result_reg;
  assign bus.zf        = zf_reg;
  assign bus.sf        = sf_reg;
`ifdef LOGIC_UNIT_PARITY_EN
  assign bus.pf        = pf_reg;
`endif

endmodule
